// File: rtl/pwm_audio_out.sv
// Sample FIFO feeding a fixed-rate PWM DAC with volume shift and mute.
// Latency: a sample popped at boundary T drives pwm_out from T+2^PWM_BITS+2.
// Backpressure: sample_ready_out drops while the FIFO is full or in reset.

// Generic synchronous FIFO, registered storage, no write-to-read bypass.
// Latency: a pushed entry is visible at rd_dat on the following cycle.
// Backpressure: wr_rdy low when full or in reset; rd_vld low when empty.
module pwm_audio_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign wr_rdy = !rst && (count != FULL);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    // pop is qualified by the pre-push count, so an entry cannot leave the cycle it arrives
    assign pop    = rd_rdy && rd_vld;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: ;
            endcase
        end
    end
endmodule

// Audio PWM output stage: buffers samples, releases one per sample period.
// Latency: boundary T -> cur_sample T+1 -> duty_reg T+2^PWM_BITS -> pwm_out T+2^PWM_BITS+2.
// Backpressure: sample_ready_out low when the 4-entry buffer is full or in reset.
module pwm_audio_out #(
    parameter int PWM_BITS        = 8,
    parameter int CLKS_PER_SAMPLE = 512,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    output logic        sample_ready_out,
    input  logic [2:0]  volume_in,
    input  logic        mute_in,
    output logic        pwm_out,
    output logic        sample_tick_out,
    output logic        underflow_out
);
    localparam int PCW = $clog2(CLKS_PER_SAMPLE);
    localparam logic [PCW-1:0]      LAST_CNT = PCW'(CLKS_PER_SAMPLE - 1);
    localparam logic [PWM_BITS-1:0] MID      = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PCW-1:0]      period_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                boundary;
    logic                frame_end;
    logic                fifo_vld;
    logic [15:0]         fifo_dat;
    logic signed [15:0]  cur_sample;
    logic signed [15:0]  s;
    logic [15:0]         u;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_reg;

    assign pwm_cnt   = period_cnt[PWM_BITS-1:0];
    assign boundary  = !rst && (period_cnt == LAST_CNT);
    assign frame_end = (pwm_cnt == {PWM_BITS{1'b1}});

    pwm_audio_fifo #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (sample_valid_in),
        .wr_dat (sample_in),
        .wr_rdy (sample_ready_out),
        .rd_vld (fifo_vld),
        .rd_rdy (boundary),
        .rd_dat (fifo_dat)
    );

    assign sample_tick_out = boundary;
    assign underflow_out   = boundary && !fifo_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (period_cnt == LAST_CNT) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sample <= '0;
        end else if (boundary && fifo_vld) begin
            cur_sample <= fifo_dat;
        end
    end

    // Signed attenuation, then flip the sign bit for offset binary.
    assign s    = cur_sample >>> volume_in;
    assign u    = {~s[15], s[14:0]};
    assign duty = mute_in ? MID : PWM_BITS'(u >> (16 - PWM_BITS));

    // Duty only changes on the last clock of a frame, so every frame is whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_reg <= MID;
            pwm_out  <= 1'b0;
        end else begin
            if (frame_end) begin
                duty_reg <= duty;
            end
            pwm_out <= (pwm_cnt < duty_reg);
        end
    end
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: PWM duty is measured by counting high clocks per frame.
module tb_pwm_audio_out;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic        sample_ready_out;
    logic [2:0]  volume_in;
    logic        mute_in;
    logic        pwm_out;
    logic        sample_tick_out;
    logic        underflow_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_audio_out dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .volume_in        (volume_in),
        .mute_in          (mute_in),
        .pwm_out          (pwm_out),
        .sample_tick_out  (sample_tick_out),
        .underflow_out    (underflow_out)
    );

    task automatic push(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        sample_valid_in = 1'b1;
        sample_in       = d;
        while (!sample_ready_out && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready_out) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: ready stayed %0b, required 1", sample_ready_out);
        end
        @(negedge clk);
        sample_valid_in = 1'b0;
    endtask

    task automatic wait_tick;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick_out && n < 1100);
        if (!sample_tick_out) begin
            n_checks++; n_fail++;
            $display("FAIL tick_timeout: tick stayed %0b after %0d cycles, required 1", sample_tick_out, n);
        end
    endtask

    // From boundary T: f0 = highs over T+2..T+257, f1 = highs over T+258..T+513.
    task automatic run_period(input int toggle_k, output int f0, output int f1,
                              output int uf_t, output int n_tk, output int n_uf);
        wait_tick();
        uf_t = int'(underflow_out);
        f0 = 0; f1 = 0; n_tk = 0; n_uf = 0;
        for (int k = 1; k <= 513; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 257) f0 += int'(pwm_out);
            else if (k >= 258)      f1 += int'(pwm_out);
            n_tk += int'(sample_tick_out);
            n_uf += int'(underflow_out);
            if (k == toggle_k) mute_in = ~mute_in;
        end
    endtask

    task automatic test_reset;
        int hi = 0, early = 0, tk_at = 0, uf_at = 0;
        rst = 1'b1; sample_valid_in = 1'b0; sample_in = '0; volume_in = '0; mute_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (sample_ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", sample_ready_out); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL rst_pwm: got %0b want 0", pwm_out); end
        n_checks++; if (sample_tick_out !== 1'b0 || underflow_out !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: tick %0b uf %0b want 0 0", sample_tick_out, underflow_out); end
        rst = 1'b0;
        #1;
        n_checks++; if (sample_ready_out !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %0b want 1", sample_ready_out); end
        push(16'h7000); push(16'h7000); push(16'h7000);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (sample_ready_out !== 1'b0 || pwm_out !== 1'b0) begin n_fail++; $display("FAIL midrst_out: ready %0b pwm %0b want 0 0", sample_ready_out, pwm_out); end
        n_checks++; if (sample_tick_out !== 1'b0 || underflow_out !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: tick %0b uf %0b want 0 0", sample_tick_out, underflow_out); end
        rst = 1'b0;
        #1;
        n_checks++; if (sample_ready_out !== 1'b1 || pwm_out !== 1'b0) begin n_fail++; $display("FAIL rel2_out: ready %0b pwm %0b want 1 0", sample_ready_out, pwm_out); end
        for (int k = 1; k <= 511; k++) begin
            @(negedge clk);
            if (k <= 256) hi += int'(pwm_out);
            if (k < 511) early += int'(sample_tick_out) + int'(underflow_out);
            else begin tk_at = int'(sample_tick_out); uf_at = int'(underflow_out); end
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL rst_early_pulse: got %0d want 0", early); end
        n_checks++; if (tk_at !== 1) begin n_fail++; $display("FAIL rst_first_tick: got %0d want 1", tk_at); end
        n_checks++; if (uf_at !== 1) begin n_fail++; $display("FAIL rst_flush_underflow: got %0d want 1", uf_at); end
        n_checks++; if (hi !== 128) begin n_fail++; $display("FAIL rst_duty: got %0d want 128", hi); end
    endtask

    task automatic test_full_scale;
        int f0, f1, uf, nt, nu;
        push(16'h7FFF);
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== 128) begin n_fail++; $display("FAIL max_prev_frame: got %0d want 128", f0); end
        n_checks++; if (f1 !== 255) begin n_fail++; $display("FAIL max_duty: got %0d want 255", f1); end
        n_checks++; if (uf !== 0) begin n_fail++; $display("FAIL max_underflow: got %0d want 0", uf); end
        push(16'h8000);
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== 255) begin n_fail++; $display("FAIL min_prev_frame: got %0d want 255", f0); end
        n_checks++; if (f1 !== 0) begin n_fail++; $display("FAIL min_duty: got %0d want 0", f1); end
    endtask

    task automatic test_volume_mute;
        int f0, f1, uf, nt, nu;
        volume_in = 3'd1;
        push(16'h4000);
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== 64) begin n_fail++; $display("FAIL vol1_neg: got %0d want 64", f0); end
        n_checks++; if (f1 !== 160) begin n_fail++; $display("FAIL vol1_duty: got %0d want 160", f1); end
        volume_in = 3'd2;
        push(16'hC000);
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== 144) begin n_fail++; $display("FAIL vol2_prev: got %0d want 144", f0); end
        n_checks++; if (f1 !== 112) begin n_fail++; $display("FAIL vol2_duty: got %0d want 112", f1); end
        mute_in = 1'b1;
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== 128 || f1 !== 128) begin n_fail++; $display("FAIL mute_duty: got %0d/%0d want 128/128", f0, f1); end
        run_period(100, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== 128) begin n_fail++; $display("FAIL unmute_midframe: got %0d want 128", f0); end
        n_checks++; if (f1 !== 112) begin n_fail++; $display("FAIL unmute_next: got %0d want 112", f1); end
        run_period(300, f0, f1, uf, nt, nu);
        n_checks++; if (f1 !== 112) begin n_fail++; $display("FAIL mute_midframe: got %0d want 112", f1); end
        mute_in = 1'b0;
        volume_in = 3'd0;
    endtask

    task automatic test_fifo_full;
        logic [15:0] s [6];
        int want [6];
        int idx = 0, cyc = 0, ntick = 0, before_pop = 0;
        int t1 = -10, t2 = -10, a4 = -10, a5 = -20, a6 = -20;
        int f0, f1, uf, nt, nu;
        logic acc;
        logic rdy4 = 1'b1;
        s    = '{16'h1000, 16'h2000, 16'hE000, 16'h7000, 16'h0000, 16'hF000};
        want = '{144, 160, 96, 240, 128, 112};
        @(negedge clk);
        sample_valid_in = 1'b1;
        sample_in = s[0];
        while (idx < 6 && cyc < 3000) begin
            if (idx == 4 && cyc == a4 + 1) rdy4 = sample_ready_out;
            acc = sample_ready_out;
            if (sample_tick_out) begin
                ntick++;
                if (ntick == 1) t1 = cyc;
                if (ntick == 2) t2 = cyc;
            end
            if (acc) begin
                if (ntick == 0) before_pop++;
                if (idx == 3) a4 = cyc;
                if (idx == 4) a5 = cyc;
                if (idx == 5) a6 = cyc;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 6) sample_in = s[idx];
                else sample_valid_in = 1'b0;
            end
        end
        sample_valid_in = 1'b0;
        n_checks++; if (idx !== 6) begin n_fail++; $display("FAIL full_accepted: got %0d want 6", idx); end
        n_checks++; if (before_pop !== 4) begin n_fail++; $display("FAIL full_before_pop: got %0d want 4", before_pop); end
        n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL full_ready_drop: got %0b want 0", rdy4); end
        n_checks++; if (a5 !== t1 + 1) begin n_fail++; $display("FAIL full_accept5: cycle %0d want %0d", a5, t1 + 1); end
        n_checks++; if (a6 !== t2 + 1) begin n_fail++; $display("FAIL full_accept6: cycle %0d want %0d", a6, t2 + 1); end
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== want[1] || f1 !== want[2]) begin n_fail++; $display("FAIL order_s1s2: got %0d/%0d want %0d/%0d", f0, f1, want[1], want[2]); end
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (f0 !== want[3] || f1 !== want[4]) begin n_fail++; $display("FAIL order_s3s4: got %0d/%0d want %0d/%0d", f0, f1, want[3], want[4]); end
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (uf !== 1 || f0 !== want[5] || f1 !== want[5]) begin n_fail++; $display("FAIL order_s5: uf %0d duty %0d/%0d want 1 %0d/%0d", uf, f0, f1, want[5], want[5]); end
    endtask

    task automatic test_underflow;
        int f0, f1, uf, nt, nu;
        push(16'h3000);
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (uf !== 0 || f0 !== 112 || f1 !== 176) begin n_fail++; $display("FAIL uf_pop: uf %0d duty %0d/%0d want 0 112/176", uf, f0, f1); end
        n_checks++; if (nu !== 1 || nt !== 1) begin n_fail++; $display("FAIL uf_pulse1: uf %0d tick %0d want 1 1", nu, nt); end
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (uf !== 1 || f0 !== 176 || f1 !== 176) begin n_fail++; $display("FAIL uf_hold: uf %0d duty %0d/%0d want 1 176/176", uf, f0, f1); end
        n_checks++; if (nu !== 1 || nt !== 1) begin n_fail++; $display("FAIL uf_pulse2: uf %0d tick %0d want 1 1", nu, nt); end
    endtask

    task automatic test_back_to_back;
        int f0, f1, uf, nt, nu;
        push(16'h5000);
        push(16'hB000);
        wait_tick();
        n_checks++; if (underflow_out !== 1'b0) begin n_fail++; $display("FAIL b2b_tick_uf: got %0b want 0", underflow_out); end
        sample_valid_in = 1'b1;
        sample_in = 16'h9000;
        n_checks++; if (sample_ready_out !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", sample_ready_out); end
        @(negedge clk);
        sample_valid_in = 1'b0;
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (uf !== 0 || f0 !== 208 || f1 !== 48) begin n_fail++; $display("FAIL b2b_pop: uf %0d duty %0d/%0d want 0 208/48", uf, f0, f1); end
        n_checks++; if (nu !== 0) begin n_fail++; $display("FAIL b2b_tail: underflows %0d want 0", nu); end
        run_period(0, f0, f1, uf, nt, nu);
        n_checks++; if (uf !== 1 || f0 !== 16 || f1 !== 16) begin n_fail++; $display("FAIL b2b_drain: uf %0d duty %0d/%0d want 1 16/16", uf, f0, f1); end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_volume_mute();
        test_fifo_full();
        test_underflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Audio output stage that consumes the signed 16-bit sample stream from the sine generator (or any sample source) and drives a 1-bit PWM pin for an RC-filtered speaker/headphone output. Incoming samples are buffered in a small FIFO, released at a fixed sample rate, attenuated or muted, converted to offset binary, and rendered as a glitch-free PWM duty cycle. The block reports FIFO underflow so the upstream source can be rate-checked.

## Interface
- `PWM_BITS`, 8: PWM resolution. Duty value width; the PWM frame is 2^PWM_BITS clocks.
- `CLKS_PER_SAMPLE`, 512: clocks per output sample. Must be an integer multiple of 2^PWM_BITS and at least 2^PWM_BITS.
- `FIFO_DEPTH`, 4: input buffer entries; power of two.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_in` in 16: signed two's-complement sample.
- `sample_valid_in` in 1: `sample_in` is valid this cycle.
- `sample_ready_out` out 1: FIFO can accept; a transfer occurs when valid and ready are both high.
- `volume_in` in 3: attenuation; the sample is arithmetic-right-shifted by this amount.
- `mute_in` in 1: force mid-scale output.
- `pwm_out` out 1: registered PWM output.
- `sample_tick_out` out 1: one-cycle pulse on each sample-period boundary.
- `underflow_out` out 1: one-cycle pulse when a boundary finds the FIFO empty.

## Operation
- **Period counter.** `period_cnt` counts 0 to CLKS_PER_SAMPLE-1 and wraps. `pwm_cnt` = `period_cnt[PWM_BITS-1:0]`, so PWM frames stay aligned to sample boundaries.
- **FIFO.**
  - `sample_ready_out` = (count != FIFO_DEPTH), combinational from count.
  - Push on valid && ready.
  - Push and pop in the same cycle: count unchanged.
  - No bypass: a sample pushed into an empty FIFO cannot be popped in the same cycle.
- **Boundary cycle** (`period_cnt` == CLKS_PER_SAMPLE-1):
  - `sample_tick_out`=1.
  - If the FIFO is non-empty, pop the head into `cur_sample`.
  - If the FIFO is empty, `cur_sample` holds its value and `underflow_out`=1.
- **Conversion** (combinational from `cur_sample`):
  - `s` = `cur_sample` >>> `volume_in`.
  - `u` = {~s[15], s[14:0]}, i.e. offset binary.
  - `duty` = `u[15:16-PWM_BITS]`.
  - `mute_in`=1 forces `duty` = 2^(PWM_BITS-1).
- **Duty register.** `duty_reg` loads `duty` only on cycles where `pwm_cnt` == 2^PWM_BITS-1. Changes to `volume_in` or `mute_in` mid-frame never alter the current frame.
- **PWM.** `pwm_out` <= (`pwm_cnt` < `duty_reg`). High for `duty_reg` clocks per frame: 0 means always low; 2^PWM_BITS-1 means low for 1 clock per frame.

## Timing
- **While `rst` is high, and on the first cycle after release:**
  - `period_cnt`=0, FIFO empty (contents discarded), `cur_sample`=0.
  - `duty_reg`=2^(PWM_BITS-1), i.e. 128 at default parameters.
  - `pwm_out`=0, `sample_tick_out`=0, `underflow_out`=0.
  - `sample_ready_out`=0 while in reset, 1 on the first cycle after release.
- **Reset mid-operation** behaves identically: no partial frame completes and all queued samples are lost.
- **First boundary** after reset release is at cycle CLKS_PER_SAMPLE-1, counting the first post-reset cycle as 0.
- **Latency, boundary cycle T to PWM output:**
  - `cur_sample` is updated at T+1.
  - `duty_reg` loads it at the next `pwm_cnt` wrap, cycle T+2^PWM_BITS.
  - The new frame starts at `pwm_cnt`=0 on cycle T+2^PWM_BITS+1.
  - `pwm_out` reflects it from cycle T+2^PWM_BITS+2, because `pwm_out` is registered.
  - Upshot: the first frame after a pop still uses the previous sample.
- **Full FIFO:** `sample_ready_out` goes low the cycle after the 4th accepted push without a pop. It returns high the cycle after a pop.
- **Pulse width:** `underflow_out` and `sample_tick_out` are exactly one cycle wide and never assert during reset.

## Test plan
1. **Reset values.** Assert `rst` mid-frame with 3 samples queued, release → all outputs hold their reset values, `sample_ready_out`=1 on the first post-reset cycle, and the next boundary reports `underflow_out`=1 (queue was flushed).
2. **Full scale.** Push 0x7FFF, `volume_in`=0 → after the latency, `duty_reg`=255 and `pwm_out` is high 255 of every 256 clocks. Push 0x8000 → `duty_reg`=0 and `pwm_out` stays low.
3. **Volume and mute.** Push 0x4000 with `volume_in`=1 → `duty_reg`=160 (0x2000 → offset 0xA000). Push 0xC000 with `volume_in`=2 → 0xF000 → `duty_reg`=112. Set `mute_in`=1 → `duty_reg`=128. Toggle `mute_in` mid-frame → `duty_reg` changes only at a `pwm_cnt` wrap.
4. **FIFO full.** Hold `sample_valid_in` high with 6 distinct samples → exactly 4 accepted before the first pop and `sample_ready_out` drops. Then 1 more is accepted per boundary, and the pop order matches push order.
5. **Underflow.** Starve the input after one sample → `underflow_out` pulses once per boundary, `cur_sample` holds the last value, and the PWM duty is unchanged.
6. **Simultaneous push and pop.** Push on a boundary cycle with 2 entries queued → the count stays 2, the head is popped, and the new sample is stored at the tail.
